// File: rtl/seq_trigger_detector_pkg.sv
// Shared types and helpers for the sequence-trigger monitor.
package seq_trig_pkg;

  // Monitor progress: IDLE has no matches, TRACK is part-way, FIRED has seen the whole sequence.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FIRED = 2'd2
  } state_e;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/seq_trigger_detector_if.sv
// Bus bundle between the monitored datapath and the sequence-trigger monitor.
interface seq_trigger_detector_if
  import seq_trig_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4
);

  localparam int SW = clog2_min1(DEPTH + 1);

  logic                    en;
  logic                    clr;
  logic                    data_vld;
  logic [DATA_W-1:0]       data;
  logic [DEPTH*DATA_W-1:0] pattern;
  logic                    trig;
  logic                    trig_pulse;
  logic [SW-1:0]           stage;

  // Datapath side: presents samples and patterns, observes the trigger.
  modport master (
    output en, clr, data_vld, data, pattern,
    input  trig, trig_pulse, stage
  );

  // Monitor side.
  modport slave (
    input  en, clr, data_vld, data, pattern,
    output trig, trig_pulse, stage
  );

endinterface

// File: rtl/seq_trigger_detector_timer.sv
// Inter-match timeout counter; collapses to a constant "never expires" when TIMEOUT is 0.
module seq_trig_timer
  import seq_trig_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int TW = clog2_min1(TIMEOUT + 1);

  generate
    if (TIMEOUT > 0) begin : g_timer
      localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

      logic [TW-1:0] count_q;

      // Count idle cycles between matches; clear has priority over increment.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_q <= '0;
        end else if (clr) begin
          count_q <= '0;
        end else if (inc) begin
          count_q <= count_q + 1'b1;
        end
      end

      // Expiry is flagged during the last permitted idle cycle so the caller can
      // still let a match in that same cycle win.
      assign expire = (count_q == LAST);
    end else begin : g_tied
      logic unused_ctrl;

      assign unused_ctrl = clr ^ inc ^ clk ^ rst_n;
      assign expire      = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/seq_trigger_detector.sv
// Sequence-trigger monitor: fires once DEPTH programmed patterns are seen in order on the bus.
module seq_trigger_detector
  import seq_trig_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int DEPTH   = 4,
  parameter int STRICT  = 0,
  parameter int TIMEOUT = 0,
  parameter int STICKY  = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_trigger_detector_if.slave bus
);

  localparam int SW = clog2_min1(DEPTH + 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(DEPTH);

  generate
    if (DEPTH < 1 || DATA_W < 1) begin : g_bad_cfg
      $error("seq_trigger_detector: DEPTH and DATA_W must both be at least 1");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic [SW-1:0]     base_stage;
  logic              trig_q, pulse_q;
  logic              enter_fired;
  logic              armed;
  logic              sample;
  logic              hit;
  logic              hit_first;
  logic              tmr_clr, tmr_inc, tmr_expire;
  logic [DATA_W-1:0] pats [DEPTH];

  // Unpack the pattern bus and compare the sample against the pattern due next.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      pats[k] = bus.pattern[k*DATA_W +: DATA_W];
    end
    // A pulse-mode FIRED cycle already behaves as IDLE for the incoming sample.
    armed      = (state_q != FIRED) || (STICKY == 0);
    base_stage = (state_q == FIRED) ? '0 : stage_q;
    sample     = bus.en & bus.data_vld;
    hit        = sample && (bus.data == pats[base_stage]);
    hit_first  = (bus.data == pats[0]);
  end

  // Next-state, stage and timer control; clear beats everything, then a match beats timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    stage_d     = stage_q;
    enter_fired = 1'b0;
    tmr_clr     = 1'b0;
    tmr_inc     = 1'b0;

    if (bus.clr) begin
      state_d = IDLE;
      stage_d = '0;
      tmr_clr = 1'b1;
    end else if (!armed) begin
      // Sticky FIRED: hold everything until clear or reset.
      tmr_clr = 1'b1;
    end else begin
      stage_d = base_stage;
      state_d = (base_stage == '0) ? IDLE : TRACK;
      if (hit) begin
        stage_d = base_stage + 1'b1;
        tmr_clr = 1'b1;
        if (stage_d == LAST_STAGE) begin
          state_d     = FIRED;
          enter_fired = 1'b1;
        end else begin
          state_d = TRACK;
        end
      end else if (sample && (STRICT != 0)) begin
        // A stray sample restarts the sequence, reusing it as the first element if it fits.
        stage_d = hit_first ? SW'(1) : '0;
        state_d = hit_first ? TRACK : IDLE;
        tmr_clr = 1'b1;
      end else if ((state_q == TRACK) && bus.en) begin
        if (tmr_expire) begin
          stage_d = '0;
          state_d = IDLE;
          tmr_clr = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end else if (state_q != TRACK) begin
        tmr_clr = 1'b1;
      end
    end
  end

  // State, progress and registered trigger outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments make every flop here update from pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      trig_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      trig_q  <= (state_d == FIRED);
      pulse_q <= enter_fired;
    end
  end

  seq_trig_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .inc    (tmr_inc),
    .expire (tmr_expire)
  );

  assign bus.trig       = trig_q;
  assign bus.trig_pulse = pulse_q;
  assign bus.stage      = stage_q;

endmodule

// File: tb/tb_seq_trigger_detector.sv
// Self-checking bench: five parameter variants share one stimulus stream and are
// each compared every cycle against a behavioural model of the sequence rules.
module tb_seq_trigger_detector;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 4;
  localparam int NCFG   = 5;
  localparam int CFG_STRICT  [NCFG] = '{0, 1, 0, 0, 1};
  localparam int CFG_TIMEOUT [NCFG] = '{0, 0, 8, 0, 3};
  localparam int CFG_STICKY  [NCFG] = '{1, 1, 1, 0, 0};

  localparam logic [DATA_W-1:0] JUNK = 128'hdeadbeef;

  logic clk = 1'b0;
  logic rst_n;
  logic en, clr, data_vld;
  logic [DATA_W-1:0]       data;
  logic [DEPTH*DATA_W-1:0] pattern;
  logic [DATA_W-1:0]       pat [DEPTH];

  logic [2:0] obs_stage [NCFG];
  logic       obs_trig  [NCFG];
  logic       obs_pulse [NCFG];

  int  m_stage [NCFG];
  int  m_timer [NCFG];
  bit  m_trig  [NCFG];
  bit  m_pulse [NCFG];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NCFG; g++) begin : g_dut
      seq_trigger_detector_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus_i ();

      assign bus_i.en       = en;
      assign bus_i.clr      = clr;
      assign bus_i.data_vld = data_vld;
      assign bus_i.data     = data;
      assign bus_i.pattern  = pattern;
      assign obs_stage[g]   = bus_i.stage;
      assign obs_trig[g]    = bus_i.trig;
      assign obs_pulse[g]   = bus_i.trig_pulse;

      seq_trigger_detector #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .STRICT  (CFG_STRICT[g]),
        .TIMEOUT (CFG_TIMEOUT[g]),
        .STICKY  (CFG_STICKY[g])
      ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_i)
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCFG; c++) begin
      m_stage[c] = 0;
      m_timer[c] = 0;
      m_trig[c]  = 1'b0;
      m_pulse[c] = 1'b0;
    end
  endtask

  // One clock edge of the sequence rules, using the inputs held during the cycle.
  task automatic model_step();
    bit smp;
    smp = en && data_vld;
    for (int c = 0; c < NCFG; c++) begin
      if (clr) begin
        m_stage[c] = 0; m_timer[c] = 0; m_trig[c] = 1'b0; m_pulse[c] = 1'b0;
      end else if (m_stage[c] == DEPTH && CFG_STICKY[c] != 0) begin
        m_pulse[c] = 1'b0;
      end else begin
        if (m_stage[c] == DEPTH) m_stage[c] = 0;
        m_trig[c]  = 1'b0;
        m_pulse[c] = 1'b0;
        if (smp && data == pat[m_stage[c]]) begin
          m_stage[c]++;
          m_timer[c] = 0;
          if (m_stage[c] == DEPTH) begin
            m_trig[c]  = 1'b1;
            m_pulse[c] = 1'b1;
          end
        end else if (smp && CFG_STRICT[c] != 0) begin
          m_stage[c] = (data == pat[0]) ? 1 : 0;
          m_timer[c] = 0;
        end else if (m_stage[c] > 0 && en && CFG_TIMEOUT[c] > 0) begin
          if (m_timer[c] == CFG_TIMEOUT[c] - 1) begin
            m_stage[c] = 0;
            m_timer[c] = 0;
          end else begin
            m_timer[c]++;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("cfg%0d_stage", c), DATA_W'(obs_stage[c]), DATA_W'(m_stage[c]));
      check($sformatf("cfg%0d_trig", c),  DATA_W'(obs_trig[c]),  DATA_W'(m_trig[c]));
      check($sformatf("cfg%0d_pulse", c), DATA_W'(obs_pulse[c]), DATA_W'(m_pulse[c]));
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare just after it.
  task automatic cycle(input bit e, input bit v, input bit c, input logic [DATA_W-1:0] d);
    en = e; data_vld = v; clr = c; data = d;
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
    compare_all();
  endtask

  task automatic feed(input logic [DATA_W-1:0] d);
    cycle(1'b1, 1'b1, 1'b0, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, JUNK);
  endtask

  task automatic clear();
    cycle(1'b1, 1'b0, 1'b1, JUNK);
  endtask

  initial begin
    pat[0] = 128'h3243f6a8_885a308d_313198a2_e0370734;
    pat[1] = 128'h00112233_44556677_8899aabb_ccddeeff;
    pat[2] = 128'h0;
    pat[3] = 128'h1;
    pattern = {pat[3], pat[2], pat[1], pat[0]};
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; data_vld = 1'b0; data = JUNK;
    model_reset();
    #12;
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("rst%0d_stage", c), DATA_W'(obs_stage[c]), '0);
      check($sformatf("rst%0d_trig", c),  DATA_W'(obs_trig[c]),  '0);
      check($sformatf("rst%0d_pulse", c), DATA_W'(obs_pulse[c]), '0);
    end
    #11 rst_n = 1'b1;

    // Ordered match with idle fillers, sticky hold, then clear.
    feed(pat[0]); idle(1);
    feed(pat[1]); idle(1);
    feed(pat[2]); idle(1);
    feed(pat[3]);
    check("ord_stage", DATA_W'(obs_stage[0]), DATA_W'(4));
    check("ord_trig",  DATA_W'(obs_trig[0]),  DATA_W'(1));
    check("ord_pulse", DATA_W'(obs_pulse[0]), DATA_W'(1));
    idle(1);
    check("ord_pulse_end", DATA_W'(obs_pulse[0]), '0);
    idle(100);
    check("ord_hold", DATA_W'(obs_trig[0]), DATA_W'(1));
    clear();
    check("ord_clr_trig",  DATA_W'(obs_trig[0]),  '0);
    check("ord_clr_stage", DATA_W'(obs_stage[0]), '0);

    // Strict: a stray sample breaks the sequence; a stray p0 restarts at 1.
    feed(pat[0]); check("strict_s1", DATA_W'(obs_stage[1]), DATA_W'(1));
    feed(pat[1]); check("strict_s2", DATA_W'(obs_stage[1]), DATA_W'(2));
    feed(JUNK);   check("strict_s3", DATA_W'(obs_stage[1]), '0);
    feed(pat[2]); check("strict_s4", DATA_W'(obs_stage[1]), '0);
    check("strict_notrig", DATA_W'(obs_trig[1]), '0);
    clear();
    feed(pat[0]); feed(pat[1]); feed(pat[0]);
    check("strict_restart", DATA_W'(obs_stage[1]), DATA_W'(1));
    clear();

    // Timeout of 8: expiry on the 8th idle cycle, and a match in that cycle wins.
    feed(pat[0]); idle(7);
    check("to_before", DATA_W'(obs_stage[2]), DATA_W'(1));
    idle(1);
    check("to_expire", DATA_W'(obs_stage[2]), '0);
    feed(pat[0]); idle(7); feed(pat[1]);
    check("to_match_wins", DATA_W'(obs_stage[2]), DATA_W'(2));
    clear();

    // Pulse mode: one-cycle trigger, FIRED cycle sample counts as the first element.
    feed(pat[0]); feed(pat[1]); feed(pat[2]); feed(pat[3]);
    check("pm_trig",  DATA_W'(obs_trig[3]),  DATA_W'(1));
    check("pm_pulse", DATA_W'(obs_pulse[3]), DATA_W'(1));
    feed(pat[0]);
    check("pm_trig_off", DATA_W'(obs_trig[3]),  '0);
    check("pm_rearm",    DATA_W'(obs_stage[3]), DATA_W'(1));
    clear();

    // Clear beats a simultaneous final match.
    feed(pat[0]); feed(pat[1]); feed(pat[2]);
    cycle(1'b1, 1'b1, 1'b1, pat[3]);
    check("clr_prio_trig",  DATA_W'(obs_trig[0]),  '0);
    check("clr_prio_stage", DATA_W'(obs_stage[0]), '0);

    // Asynchronous reset between edges while tracking.
    feed(pat[0]); feed(pat[1]);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_stage", DATA_W'(obs_stage[0]), '0);
    compare_all();
    idle(1);
    #3 rst_n = 1'b1;

    // Gating: en or data_vld low blocks progress; en low freezes the timer.
    cycle(1'b0, 1'b1, 1'b0, pat[0]);
    check("gate_en", DATA_W'(obs_stage[0]), '0);
    cycle(1'b1, 1'b0, 1'b0, pat[0]);
    check("gate_vld", DATA_W'(obs_stage[0]), '0);
    feed(pat[0]);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, JUNK);
    check("gate_frozen", DATA_W'(obs_stage[2]), DATA_W'(1));
    clear();

    // Randomised traffic biased towards pattern values.
    for (int i = 0; i < 3000; i++) begin
      logic [DATA_W-1:0] d;
      bit e, v, c;
      if ($urandom_range(9) < 6) d = pat[$urandom_range(DEPTH - 1)];
      else d = {$urandom, $urandom, $urandom, $urandom};
      e = ($urandom_range(9) != 0);
      v = ($urandom_range(4) != 0);
      c = ($urandom_range(39) == 0);
      cycle(e, v, c, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_trigger_detector.md
Name: seq_trigger_detector

Overview:
Parametrised sequence-trigger monitor for the AES datapath. It watches a DATA_W-bit state bus and asserts a trigger once DEPTH programmed patterns have been seen in order. It adds strict and relaxed matching, an inter-match timeout, sticky or pulse trigger modes, and synchronous clear. It is clocked and registered, and sits beside the AES round logic, feeding the payload block.

Parameters:
DATA_W, 128, width of monitored state bus and of each pattern
DEPTH, 4, number of patterns in the sequence (>=1)
STRICT, 0, 0 = non-matching samples ignored; 1 = non-matching sample breaks the sequence
TIMEOUT, 0, max cycles allowed between consecutive matches; 0 disables the timeout
STICKY, 1, 1 = trig held until clr/reset; 0 = single-cycle trig, then re-arm

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  monitor enable; when low, samples are ignored and the timer is frozen
clr  in  1  synchronous clear of progress, timer and trig
data_vld  in  1  data qualifies as a sample this cycle
data  in  DATA_W  monitored state bus
pattern  in  DEPTH*DATA_W  pattern k at [k*DATA_W +: DATA_W]; quasi-static
trig  out  1  trigger output, registered
trig_pulse  out  1  one-cycle strobe on entry to FIRED
stage  out  SW  current progress 0..DEPTH, where SW = $clog2(DEPTH+1)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: trig=0, trig_pulse=0, stage=0, timer=0, state=IDLE.
- Sample definition: a sample is a cycle with en=1, data_vld=1 and clr=0. Matching is against pattern[stage], full-width equality.
- States: IDLE (stage=0), TRACK (0<stage<DEPTH), FIRED (stage=DEPTH).
- IDLE or TRACK, matching sample: stage+1 and timer cleared. If the new stage equals DEPTH, go to FIRED.
- Latency: a matching final sample at edge t gives trig=1 and trig_pulse=1 after edge t, i.e. visible in cycle t+1.
- Non-matching sample, STRICT=0: no change.
- Non-matching sample, STRICT=1: if data==pattern[0], stage=1; else stage=0. The timer clears.
- Timeout (TIMEOUT>0, state TRACK, en=1): timer increments every cycle without a match. When timer==TIMEOUT-1 and no match occurs this cycle, stage=0 and timer=0 next cycle.
- Timeout vs match: a match in the expiry cycle wins and advances.
- Timer in other states: held at 0 in IDLE and FIRED.
- FIRED, STICKY=1: trig stays 1, stage stays DEPTH, and samples are ignored until clr or reset.
- FIRED, STICKY=0: trig is high for exactly one cycle. On the next edge the block returns to IDLE (stage=0), and that cycle's sample is evaluated against pattern[0].
- trig_pulse: high only in the first FIRED cycle, in both modes.
- clr: highest synchronous priority. It forces IDLE, stage=0, trig=0 and timer=0 on the next edge, overriding a simultaneous match.
- Async reset mid-sequence or while FIRED: immediate return to reset values.
- DEPTH=1: the first match goes straight from IDLE to FIRED.
- Elaboration checks: error if DEPTH<1 or DATA_W<1. The timer width is $clog2(TIMEOUT+1), with a minimum of 1.

Decomposition:
- Package seq_trig_pkg holds:
  - state enum {IDLE, TRACK, FIRED} as 2-bit
  - a helper function for clog2 with a floor of 1
- Natural sub-module: seq_trig_timer. It provides the timeout counter with clear, enable and an expire output, parametrised by TIMEOUT, and is tied off when TIMEOUT=0.
- The main module contains the pattern mux, the compare, and the FSM and stage register.

Test Plan:
- Ordered match, defaults: pattern = {3243f6a8_885a308d_313198a2_e0370734, 00112233_44556677_8899aabb_ccddeeff, 0, 1}. Drive the four values in order with fillers between → stage goes 1,2,3,4; trig=1 from the cycle after the 4th; trig_pulse lasts one cycle; trig is held for 100 cycles; clr gives trig=0 and stage=0.
- STRICT=1: drive p0, p1, then 0xdeadbeef, then p2 → stage 1,2,0,0 and no trig. Drive p0, p1, p0 → stage 1,2,1.
- TIMEOUT=8: drive p0, then 8 idle cycles → stage returns to 0 on the 8th. Repeat with p1 arriving on the 8th cycle → stage=2 (match wins).
- STICKY=0: drive p0..p3 then p0 immediately → trig high for exactly 1 cycle, then stage=1 on the following sample.
- Priority: clr asserted with the final pattern → trig stays 0 and stage=0. Deassert rst_n asynchronously mid-TRACK (between edges) → stage=0 immediately.
- Gating: en=0 or data_vld=0 while the pattern is presented → no advance; with TIMEOUT=8 and en=0 for 20 cycles the stage is preserved.
